// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-divider controller slice.
// Optional feature macro used by this slice: CLKDIV_CTRL_SETTLE_EN.
package clkdiv_pkg;

    localparam int unsigned CNT_W = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SETTLE,
        ST_APPLY
    } state_t;

    // Divide ratio P = 2^(sel+1): 2, 4, 8, 16.
    function automatic logic [CNT_W:0] period_of(input sel_t sel);
        logic [CNT_W:0] one;
        one = {{CNT_W{1'b0}}, 1'b1};
        return one << ({1'b0, sel} + 3'd1);
    endfunction

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// Ratio-change request handshake between the requester and clkdiv_ctrl.
interface clkdiv_ctrl_if;
    import clkdiv_pkg::*;

    logic req_valid_i;
    sel_t req_sel_i;
    logic req_ready_o;

    modport master (output req_valid_i, output req_sel_i, input req_ready_o);
    modport slave  (input req_valid_i, input req_sel_i, output req_ready_o);

endinterface

// File: rtl/clkdiv_cnt.sv
// Period counter for the divided clock: counts 0..P-1 and wraps, and
// reports the boundary of the current count plus compares on the next count
// so the owner can register dclk/tick directly from flops.
module clkdiv_cnt
    import clkdiv_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  sel_t sel_i,
    input  logic hold_i,
    input  logic clear_i,
    output logic boundary_o,
    output logic first_d_o,
    output logic low_half_d_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;

    // Next count and the compares derived from it.
    always_comb begin
        period       = period_of(sel_i);
        last         = period[CNT_W-1:0] - CNT_W'(1);
        half         = period[CNT_W:1];
        boundary_o   = (cnt_q == last);
        cnt_d        = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = boundary_o ? '0 : cnt_q + CNT_W'(1);
        end
        first_d_o    = (cnt_d == '0);
        low_half_d_o = (cnt_d < half);
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Divided-clock sequencing controller: owns the ratio select, gates the
// output at period boundaries and performs glitch-free ratio switches.
// Define CLKDIV_CTRL_SETTLE_EN to insert SETTLE_CYC low cycles between
// ratios; without it the single APPLY cycle is the only low gap.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter sel_t        RST_SEL    = 2'd0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    clkdiv_ctrl_if.slave        req_if,
    output logic                dclk_o,
    output logic                tick_o,
    output sel_t                sel_o,
    output logic                busy_o,
    output logic                done_o
);

    if (SETTLE_CYC == 0 || SETTLE_CYC > 15) begin : g_settle_range
        $error("SETTLE_CYC must be in 1..15");
    end

    state_t state_q, state_d;
    sel_t   sel_q, sel_d;
    sel_t   pend_q, pend_d;
    logic   gate_q, gate_d;
    logic   dclk_q, dclk_d;
    logic   tick_q, tick_d;
    logic   ready_q, busy_q, done_q;
    logic   accept;
    logic   boundary, first_d, low_half_d;
    logic   cnt_hold, cnt_clear;

`ifdef CLKDIV_CTRL_SETTLE_EN
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam state_t     ST_SWITCH   = ST_SETTLE;
    logic [3:0] scnt_q, scnt_d;
    assign cnt_hold = (state_q == ST_SETTLE);
`else
    localparam state_t     ST_SWITCH   = ST_APPLY;
    assign cnt_hold = 1'b0;
`endif

    assign cnt_clear = (state_q == ST_APPLY);
    assign accept    = req_if.req_valid_i && ready_q;

    clkdiv_cnt u_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sel_i        (sel_q),
        .hold_i       (cnt_hold),
        .clear_i      (cnt_clear),
        .boundary_o   (boundary),
        .first_d_o    (first_d),
        .low_half_d_o (low_half_d)
    );

    // Next-state and next-output decode for the switch sequence.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        gate_d  = gate_q;
`ifdef CLKDIV_CTRL_SETTLE_EN
        scnt_d  = '0;
`endif
        case (state_q)
            ST_RUN: begin
                if (boundary) begin
                    gate_d = en_i;
                end
                if (accept) begin
                    pend_d  = req_if.req_sel_i;
                    state_d = boundary ? ST_SWITCH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (boundary) begin
                    state_d = ST_SWITCH;
                end
            end
`ifdef CLKDIV_CTRL_SETTLE_EN
            ST_SETTLE: begin
                if (scnt_q == SETTLE_LAST) begin
                    state_d = ST_APPLY;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
`endif
            ST_APPLY: begin
                gate_d  = en_i;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // The new select is already visible during the APPLY cycle, so the
        // counter restarts on the new ratio straight out of APPLY.
        if (state_d == ST_APPLY) begin
            sel_d = pend_d;
        end
        // DRAIN keeps the old period running so its last pulse is never cut.
        dclk_d = gate_d && (state_d == ST_RUN || state_d == ST_DRAIN) && low_half_d;
        tick_d = gate_d && (state_d == ST_RUN) && first_d;
    end

    // FSM and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            sel_q   <= RST_SEL;
            pend_q  <= RST_SEL;
            gate_q  <= 1'b0;
            dclk_q  <= 1'b0;
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLKDIV_CTRL_SETTLE_EN
            scnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            gate_q  <= gate_d;
            dclk_q  <= dclk_d;
            tick_q  <= tick_d;
            ready_q <= (state_d == ST_RUN);
            busy_q  <= (state_d != ST_RUN);
            done_q  <= (state_d == ST_APPLY);
`ifdef CLKDIV_CTRL_SETTLE_EN
            scnt_q  <= scnt_d;
`endif
        end
    end

    assign req_if.req_ready_o = ready_q;
    assign dclk_o             = dclk_q;
    assign tick_o             = tick_q;
    assign sel_o              = sel_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed self-checking bench for clkdiv_ctrl.
// Observed vector field order: {ready, busy, done, dclk, tick, sel[1:0]}.
module tb_clkdiv_ctrl;
    import clkdiv_pkg::*;

    localparam int unsigned SC = 4;
`ifdef CLKDIV_CTRL_SETTLE_EN
    localparam int S = SC;
`else
    localparam int S = 0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    logic en_i;
    logic dclk_o, tick_o, busy_o, done_o;
    sel_t sel_o;
    int   errors = 0;
    int   checks = 0;

    clkdiv_ctrl_if req_if ();

    clkdiv_ctrl #(
        .SETTLE_CYC (SC),
        .RST_SEL    (2'd0)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .req_if (req_if),
        .dclk_o (dclk_o),
        .tick_o (tick_o),
        .sel_o  (sel_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk_i = ~clk_i;

    logic [6:0] obs;
    assign obs = {req_if.req_ready_o, busy_o, done_o, dclk_o, tick_o, sel_o};

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench in the first cycle after a reset edge (cnt = 0).
    task automatic do_reset(input logic en);
        rst_i = 1'b1;
        en_i  = en;
        req_if.req_valid_i = 1'b0;
        req_if.req_sel_i   = 2'd0;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        do_reset(1'b0);
        exp = 7'b1000000;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_vals: got %b expected %b", obs, exp); end
        rst_i = 1'b1;
        en_i  = 1'b1;
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd3;
        cyc();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_hold: got %b expected %b", obs, exp); end
        req_if.req_valid_i = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic test_enable();
        logic [6:0] exp;
        do_reset(1'b0);
        exp = 7'b1000000;
        cyc();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_b1: got %b expected %b", obs, exp); end
        cyc();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_c2: got %b expected %b", obs, exp); end
        en_i = 1'b1;
        cyc();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_b2: got %b expected %b", obs, exp); end
        for (int i = 0; i < 6; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, (i % 2 == 0), (i % 2 == 0), 2'd0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL en_toggle[%0d]: got %b expected %b", i, obs, exp); end
        end
    endtask

    task automatic test_switch_drain();
        logic [6:0] exp;
        do_reset(1'b1);
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd1;
        exp = 7'b1000000;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw1_accept: got %b expected %b", obs, exp); end
        cyc();
        req_if.req_valid_i = 1'b0;
        exp = 7'b0100000;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw1_drain: got %b expected %b", obs, exp); end
        for (int i = 0; i < S; i++) begin
            cyc();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL sw1_settle[%0d]: got %b expected %b", i, obs, exp); end
        end
        cyc();
        exp = 7'b0110001;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw1_apply: got %b expected %b", obs, exp); end
        cyc();
        exp = 7'b1001101;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL p4_c0: got %b expected %b", obs, exp); end
        cyc();
        exp = 7'b1001001;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL p4_c1: got %b expected %b", obs, exp); end
        // Accept sel 3 at cnt 1 of P=4, then hold a different request while busy.
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd3;
        cyc();
        req_if.req_sel_i   = 2'd2;
        exp = 7'b0100001;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw3_drain0: got %b expected %b", obs, exp); end
        cyc();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw3_drain1: got %b expected %b", obs, exp); end
        for (int i = 0; i < S; i++) begin
            cyc();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL sw3_settle[%0d]: got %b expected %b", i, obs, exp); end
        end
        cyc();
        req_if.req_valid_i = 1'b0;
        exp = 7'b0110011;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw3_apply: got %b expected %b", obs, exp); end
        for (int i = 0; i < 16; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, (i < 8), (i == 0), 2'd3};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL p16[%0d]: got %b expected %b", i, obs, exp); end
        end
    endtask

    task automatic test_boundary_accept();
        logic [6:0] exp;
        do_reset(1'b1);
        cyc();
        exp = 7'b1000000;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ba_pre: got %b expected %b", obs, exp); end
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd2;
        cyc();
        req_if.req_valid_i = 1'b0;
        exp = 7'b0100000;
        for (int i = 0; i < S; i++) begin
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ba_settle[%0d]: got %b expected %b", i, obs, exp); end
            cyc();
        end
        exp = 7'b0110010;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ba_apply: got %b expected %b", obs, exp); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, (i < 4), (i == 0), 2'd2};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ba_p8[%0d]: got %b expected %b", i, obs, exp); end
        end
    endtask

    task automatic test_en_drop();
        logic [6:0] exp;
        do_reset(1'b1);
        cyc();
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd3;
        cyc();
        req_if.req_valid_i = 1'b0;
        for (int i = 0; i < S; i++) cyc();
        exp = 7'b0110011;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ed_apply: got %b expected %b", obs, exp); end
        for (int i = 0; i < 16; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, (i < 8), (i == 0), 2'd3};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ed_p1[%0d]: got %b expected %b", i, obs, exp); end
            if (i == 3) en_i = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            exp = 7'b1000011;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ed_p2[%0d]: got %b expected %b", i, obs, exp); end
            if (i == 5) en_i = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, 1'b1, (i == 0), 2'd3};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ed_p3[%0d]: got %b expected %b", i, obs, exp); end
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] exp;
        do_reset(1'b1);
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd3;
        cyc();
        req_if.req_valid_i = 1'b0;
        cyc();
        exp = {1'b0, 1'b1, (S == 0), 1'b0, 1'b0, ((S == 0) ? 2'd3 : 2'd0)};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ra_mid: got %b expected %b", obs, exp); end
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        exp = 7'b1000000;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ra_reset: got %b expected %b", obs, exp); end
        for (int i = 0; i < S + 4; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, (i % 2 == 1), (i % 2 == 1), 2'd0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ra_after[%0d]: got %b expected %b", i, obs, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        do_reset(1'b1);
        cyc();
        cyc();
        exp = 7'b1001100;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lg_old_hi: got %b expected %b", obs, exp); end
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd1;
        cyc();
        req_if.req_valid_i = 1'b0;
        exp = 7'b0100000;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lg_drain: got %b expected %b", obs, exp); end
        for (int i = 0; i < S; i++) begin
            cyc();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL lg_settle[%0d]: got %b expected %b", i, obs, exp); end
        end
        cyc();
        exp = 7'b0110001;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lg_apply: got %b expected %b", obs, exp); end
        cyc();
        exp = 7'b1001101;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lg_new_c0: got %b expected %b", obs, exp); end
        // Same-select request at cnt 0 of P=4 still runs the whole sequence.
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'd1;
        cyc();
        req_if.req_valid_i = 1'b0;
        exp = 7'b0101001;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ss_drain_hi: got %b expected %b", obs, exp); end
        exp = 7'b0100001;
        for (int i = 0; i < S + 2; i++) begin
            cyc();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ss_low[%0d]: got %b expected %b", i, obs, exp); end
        end
        cyc();
        exp = 7'b0110001;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ss_apply: got %b expected %b", obs, exp); end
        cyc();
        exp = 7'b1001101;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ss_new_c0: got %b expected %b", obs, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        en_i  = 1'b0;
        req_if.req_valid_i = 1'b0;
        req_if.req_sel_i   = 2'd0;
        test_reset();
        test_enable();
        test_switch_drain();
        test_boundary_accept();
        test_en_drop();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
